// File: rtl/zxbus_regs.sv
// Register/port file behind the zxbus controller: TX FIFO, RX holding register, address shifter, command port.
// Optional scratch register at sel 3 is enabled by defining ZXBUS_REGS_SCRATCH_EN.
module zxbus_regs #(
    parameter int TXDEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_wr_stb,
    input  logic        bus_rd_stb,
    input  logic [1:0]  bus_sel,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [23:0] flash_addr,
    output logic [6:0]  cmd,
    output logic        cmd_stb,
    input  logic        eng_busy
);
    localparam int AW = $clog2(TXDEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        SEL_DATA = 2'd0,
        SEL_CMD  = 2'd1,
        SEL_ADDR = 2'd2,
        SEL_SCR  = 2'd3
    } sel_e;

    logic [7:0]  tx_mem [TXDEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        tx_full, tx_empty;
    logic        rxv, txovf, rxund;
    logic [7:0]  rx_byte;

    // Strobe decode; a write in the same cycle as a read suppresses the read side effect.
    logic wr_data, wr_cmd, wr_ctl, wr_addr, rd_data;
    logic push, pop, flush, rx_take;

    assign wr_data = bus_wr_stb && (bus_sel == SEL_DATA);
    assign wr_cmd  = bus_wr_stb && (bus_sel == SEL_CMD) && !bus_wdata[7];
    assign wr_ctl  = bus_wr_stb && (bus_sel == SEL_CMD) &&  bus_wdata[7];
    assign wr_addr = bus_wr_stb && (bus_sel == SEL_ADDR);
    assign rd_data = bus_rd_stb && !bus_wr_stb && (bus_sel == SEL_DATA);

    assign tx_empty = (wr_ptr == rd_ptr);
    assign tx_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[rd_ptr[AW-1:0]];
    assign push     = wr_data && !tx_full;
    assign pop      = tx_valid && tx_ready;
    assign flush    = wr_ctl && bus_wdata[0];
    assign rx_ready = !rxv;
    assign rx_take  = rx_valid && !rxv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tx_mem[wr_ptr[AW-1:0]] <= bus_wdata;
    end

    // An accepted engine byte always lands, even against a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxv     <= 1'b0;
            rx_byte <= 8'h00;
            txovf   <= 1'b0;
            rxund   <= 1'b0;
        end else begin
            if (rx_take) begin
                rxv     <= 1'b1;
                rx_byte <= rx_data;
            end else if ((rd_data && rxv) || (wr_ctl && bus_wdata[2])) begin
                rxv <= 1'b0;
            end
            if (wr_ctl && bus_wdata[1]) begin
                txovf <= 1'b0;
                rxund <= 1'b0;
            end else begin
                if (wr_data && tx_full) txovf <= 1'b1;
                if (rd_data && !rxv)    rxund <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flash_addr <= 24'h0;
            cmd        <= 7'h0;
            cmd_stb    <= 1'b0;
        end else begin
            cmd_stb <= wr_cmd;
            if (wr_cmd)  cmd <= bus_wdata[6:0];
            if (wr_addr) flash_addr <= {flash_addr[15:0], bus_wdata};
        end
    end

`ifdef ZXBUS_REGS_SCRATCH_EN
    logic [7:0] scratch;

    always_ff @(posedge clk) begin
        if (!rst_n)
            scratch <= 8'h00;
        else if (bus_wr_stb && (bus_sel == SEL_SCR))
            scratch <= bus_wdata;
    end
`endif

    always_comb begin
        bus_rdata = 8'h00;
        case (bus_sel)
            SEL_DATA: bus_rdata = rx_byte;
            SEL_CMD:  bus_rdata = {eng_busy, txovf, rxund, rxv, tx_full, tx_empty, 2'b00};
            SEL_ADDR: bus_rdata = flash_addr[7:0];
`ifdef ZXBUS_REGS_SCRATCH_EN
            SEL_SCR:  bus_rdata = scratch;
`else
            SEL_SCR:  bus_rdata = 8'hFF;
`endif
            default:  bus_rdata = 8'h00;
        endcase
    end
endmodule
